serial_add_ctrl: RTL and testbench

//  Sequencer that performs WIDTH-bit addition by reusing one SLICE-bit ripple-carry adder slice over

---
 rtl/serial_add_ctrl_pkg.sv | 16 +
 rtl/serial_add_ctrl_if.sv | 23 ++
 rtl/serial_add_ctrl_add_slice.sv | 23 ++
 rtl/serial_add_ctrl.sv | 103 ++++++++++
 tb/tb_serial_add_ctrl.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the slice-serial adder sequencer.
package serial_add_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_SLICE = 4;

    // Slice counter width: clog2 of the slice count, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned nslices);
        return (nslices > 1) ? $clog2(nslices) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// START/BUSY/DONE request interface between a requesting datapath and the sequencer.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, s, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, s, cout
    );
endinterface

// File: rtl/serial_add_ctrl_add_slice.sv
// Purely combinational SLICE-bit ripple-carry adder slice.
module add_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);
    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < SLICE; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[SLICE];
    end
endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer computing WIDTH-bit A+B+CIN over NSLICES cycles on one shared adder slice, LSB first.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = DEFAULT_SLICE
) (
    input logic            clk,
    input logic            rst,
    serial_add_ctrl_if.slave bus
);
    localparam int unsigned NSLICES = WIDTH / SLICE;
    localparam int unsigned CW      = cnt_width(NSLICES);
    localparam logic [CW-1:0] LAST  = CW'(NSLICES - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [WIDTH-1:0] acc;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] s_r;
    logic             cout_r;

    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;
    logic [SLICE-1:0] sl_s;
    logic             sl_cout;
    logic [WIDTH-1:0] acc_merged;

    // Constant-index mux keeps slice selection lint-clean for any NSLICES.
    always_comb begin
        sl_a       = '0;
        sl_b       = '0;
        acc_merged = acc;
        for (int unsigned k = 0; k < NSLICES; k++) begin
            if (cnt == CW'(k)) begin
                sl_a = op_a[k*SLICE +: SLICE];
                sl_b = op_b[k*SLICE +: SLICE];
                acc_merged[k*SLICE +: SLICE] = sl_s;
            end
        end
    end

    add_slice #(.SLICE(SLICE)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry),
        .s    (sl_s),
        .cout (sl_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            acc    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            s_r    <= '0;
            cout_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_a   <= bus.a;
                        op_b   <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_merged;
                    carry <= sl_cout;
                    if (cnt == LAST) begin
                        s_r    <= acc_merged;
                        cout_r <= sl_cout;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        cnt    <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.s    = s_r;
    assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed checks of the slice-serial adder at 16/4 and 8/4 configurations.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(16)) bus16 ();
    serial_add_ctrl_if #(.WIDTH(8))  bus8 ();

    serial_add_ctrl #(.WIDTH(16), .SLICE(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    serial_add_ctrl #(.WIDTH(8),  .SLICE(4)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One 16-bit sum: checks latency, BUSY during run and S holding until DONE.
    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] es, input logic ec);
        logic [15:0] prev_s;
        int n;
        @(negedge clk);
        prev_s = bus16.s;
        bus16.start = 1'b1; bus16.a = a; bus16.b = b; bus16.cin = cin;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        check({tag, "_busy0"}, 32'(bus16.busy), 32'd1);
        n = 0;
        do begin
            if (bus16.s !== prev_s) check({tag, "_hold"}, 32'(bus16.s), 32'(prev_s));
            @(posedge clk); #1;
            n++;
        end while (!bus16.done && n < 20);
        check({tag, "_lat"}, 32'(n), 32'd4);
        check({tag, "_busy_done"}, 32'(bus16.busy), 32'd0);
        check({tag, "_s"}, 32'(bus16.s), 32'(es));
        check({tag, "_cout"}, 32'(bus16.cout), 32'(ec));
        @(posedge clk); #1;
        check({tag, "_done_drop"}, 32'(bus16.done), 32'd0);
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [8:0] exp);
        int n;
        @(negedge clk);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus8.done && n < 20);
        check({tag, "_lat"}, 32'(n), 32'd2);
        check({tag, "_sum"}, 32'({bus8.cout, bus8.s}), 32'(exp));
    endtask

    initial begin
        int n, dones;
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic        vc [3];
        logic [16:0] vr [3];
        logic [7:0]  ra, rb;
        logic        rc;

        bus16.start = 0; bus16.a = '0; bus16.b = '0; bus16.cin = 0;
        bus8.start  = 0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus16.busy), 32'd0);
        check("rst_done", 32'(bus16.done), 32'd0);
        check("rst_s", 32'({bus16.cout, bus16.s}), 32'd0);
        check("rst_s8", 32'({bus8.cout, bus8.s}), 32'd0);
        @(negedge clk); rst = 1'b0;

        op16("t1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        op16("t2", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0);

        // START while busy is ignored
        @(negedge clk);
        bus16.start = 1; bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.cin = 0;
        @(negedge clk);
        bus16.start = 0;
        @(negedge clk);
        bus16.start = 1; bus16.a = 16'h0001; bus16.b = 16'h0001;
        @(negedge clk);
        bus16.start = 0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus16.done) begin
                dones++;
                check("t3_s", 32'({bus16.cout, bus16.s}), 32'h10000);
            end
        end
        check("t3_dones", 32'(dones), 32'd1);

        // Reset mid-operation
        @(negedge clk);
        bus16.start = 1; bus16.a = 16'h1234; bus16.b = 16'h4321; bus16.cin = 1;
        @(negedge clk);
        bus16.start = 0;
        @(negedge clk);
        rst = 1'b1; #1;
        check("t4_busy", 32'(bus16.busy), 32'd0);
        check("t4_done", 32'(bus16.done), 32'd0);
        check("t4_s", 32'({bus16.cout, bus16.s}), 32'd0);
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus16.done) dones++;
        end
        check("t4_nodone", 32'(dones), 32'd0);
        op16("t4b", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

        // Back-to-back with START held high
        va[0] = 16'h0001; vb[0] = 16'h0002; vc[0] = 0; vr[0] = 17'h00003;
        va[1] = 16'h8000; vb[1] = 16'h8000; vc[1] = 1; vr[1] = 17'h10001;
        va[2] = 16'hAAAA; vb[2] = 16'h5555; vc[2] = 1; vr[2] = 17'h10000;
        @(negedge clk);
        bus16.start = 1; bus16.a = va[0]; bus16.b = vb[0]; bus16.cin = vc[0];
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!bus16.done && n < 20);
            check("t5_gap", 32'(n), (k == 0) ? 32'd4 : 32'd5);
            check("t5_sum", 32'({bus16.cout, bus16.s}), 32'(vr[k]));
            if (k < 2) begin
                bus16.a = va[k+1]; bus16.b = vb[k+1]; bus16.cin = vc[k+1];
            end else begin
                bus16.start = 0;
            end
        end
        repeat (6) @(posedge clk);

        // 8-bit / 2-slice configuration
        op8("t6", 8'hF0, 8'h10, 1'b0, 9'h100);
        op8("t6b", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            op8("t6r", ra, rb, rc, 9'(ra) + 9'(rb) + 9'(rc));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
